comp_mult_arb: RTL and testbench

COMP_MULT_ARB -- requirements
Module: comp_mult_arb

---
 rtl/comp_mult_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/comp_mult_arb.sv | 119 +++++++++++
 tb/tb_comp_mult_arb.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_mult_pkg.sv
`default_nettype none
// ============================================================================
// comp_mult_pkg : shared defaults and width helpers for the arbiter slice
// Revision 1.0
// ============================================================================
package comp_mult_pkg;

    localparam int DWIDTH_DEF = 8;
    localparam int NREQ_DEF   = 4;
    localparam int OSTD_DEF   = 4;

    // Operands are {x1,y1,x2,y2}; results are {xr,yr} with two growth bits each
    function automatic int op_width(input int dw);
        return 4 * dw;
    endfunction

    function automatic int res_width(input int dw);
        return 4 * (dw + 1);
    endfunction

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int OP_W_DEF  = op_width(DWIDTH_DEF);
    localparam int RES_W_DEF = res_width(DWIDTH_DEF);
    localparam int ID_W_DEF  = id_width(NREQ_DEF);

endpackage : comp_mult_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : small synchronous FIFO with async hw reset and sync clear
// Revision 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the count covers them
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule : sync_fifo
`default_nettype wire

// File: rtl/comp_mult_arb.sv
`default_nettype none
// ============================================================================
// comp_mult_arb : round-robin front end sharing one complex multiplier
// Revision 1.0
// ============================================================================
module comp_mult_arb
    import comp_mult_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int NREQ   = NREQ_DEF,
    parameter int OSTD   = OSTD_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sw_rst,
    input  logic [NREQ-1:0]                 req_op_val,
    output logic [NREQ-1:0]                 req_op_rdy,
    input  logic [NREQ*op_width(DWIDTH)-1:0] req_op_data,
    output logic [NREQ-1:0]                 req_res_val,
    input  logic [NREQ-1:0]                 req_res_rdy,
    output logic [res_width(DWIDTH)-1:0]    req_res_data,
    output logic                            m_op_val,
    input  logic                            m_op_rdy,
    output logic [op_width(DWIDTH)-1:0]     m_op_data,
    input  logic                            m_res_val,
    output logic                            m_res_rdy,
    input  logic [res_width(DWIDTH)-1:0]    m_res_data,
    output logic                            err
);

    localparam int OPW = op_width(DWIDTH);
    localparam int IDW = id_width(NREQ);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_found;
    logic [IDW-1:0] head_id;
    logic           fifo_full;
    logic           fifo_empty;
    logic           issue;
    logic           retire;
    logic [OPW-1:0] op_slice [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign op_slice[gi] = req_op_data[gi*OPW +: OPW];
    end

    // Scan from rr_ptr upward with wrap; first valid requester wins
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin : g_scan
            logic [IDW:0]   cand;
            logic [IDW-1:0] cand_idx;
            cand = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
            cand_idx = cand[IDW-1:0];
            if (!gnt_found && req_op_val[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    assign m_op_val   = gnt_found & ~fifo_full;
    assign m_op_data  = op_slice[gnt_idx];
    assign issue      = m_op_val & m_op_rdy;
    assign req_op_rdy = issue ? (NREQ'(1) << gnt_idx) : '0;

    // Return path is steered purely by the owner at the head of the ID queue
    assign m_res_rdy    = ~fifo_empty & req_res_rdy[head_id];
    assign req_res_val  = (m_res_val & ~fifo_empty) ? (NREQ'(1) << head_id) : '0;
    assign req_res_data = m_res_data;
    assign retire       = m_res_val & m_res_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (sw_rst) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (sw_rst) begin
            err <= 1'b0;
        end else if (m_res_val && fifo_empty) begin
            err <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (IDW),
        .DEPTH (OSTD)
    ) u_id_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (sw_rst),
        .push      (issue),
        .push_data (gnt_idx),
        .pop       (retire),
        .head_data (head_id),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    a_no_issue_when_full: assert property (@(posedge clk) disable iff (rst)
        !(issue && fifo_full));
    a_op_rdy_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_op_rdy));
    a_res_val_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_res_val));

endmodule : comp_mult_arb
`default_nettype wire

// File: tb/tb_comp_mult_arb.sv
`default_nettype none
// ============================================================================
// tb_comp_mult_arb : directed and random checks against a queue-based model
// Revision 1.0
// ============================================================================
module tb_comp_mult_arb;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int OSTD = 4;
    localparam int OPW  = 4 * DW;
    localparam int RESW = 4 * (DW + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sw_rst;
    logic [NREQ-1:0]      req_op_val;
    logic [NREQ-1:0]      req_op_rdy;
    logic [NREQ*OPW-1:0]  req_op_data;
    logic [NREQ-1:0]      req_res_val;
    logic [NREQ-1:0]      req_res_rdy;
    logic [RESW-1:0]      req_res_data;
    logic                 m_op_val;
    logic                 m_op_rdy;
    logic [OPW-1:0]       m_op_data;
    logic                 m_res_val;
    logic                 m_res_rdy;
    logic [RESW-1:0]      m_res_data;
    logic                 err;

    int checks = 0;
    int errors = 0;

    // Reference model state: outstanding owners in issue order
    int q_owner[$];
    int m_ptr = 0;
    bit m_err = 1'b0;

    always #5 clk = ~clk;

    comp_mult_arb #(.DWIDTH(DW), .NREQ(NREQ), .OSTD(OSTD)) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_rst       (sw_rst),
        .req_op_val   (req_op_val),
        .req_op_rdy   (req_op_rdy),
        .req_op_data  (req_op_data),
        .req_res_val  (req_res_val),
        .req_res_rdy  (req_res_rdy),
        .req_res_data (req_res_data),
        .m_op_val     (m_op_val),
        .m_op_rdy     (m_op_rdy),
        .m_op_data    (m_op_data),
        .m_res_val    (m_res_val),
        .m_res_rdy    (m_res_rdy),
        .m_res_data   (m_res_data),
        .err          (err)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [OPW-1:0] pack_ops(input int x1, input int y1, input int x2, input int y2);
        return {DW'(x1), DW'(y1), DW'(x2), DW'(y2)};
    endfunction

    // Complex product computed arithmetically, as the multiplier would return it
    function automatic logic [RESW-1:0] cmul(input int x1, input int y1, input int x2, input int y2);
        int xr;
        int yr;
        xr = x1 * x2 - y1 * y2;
        yr = x1 * y2 + y1 * x2;
        return {(RESW/2)'(xr), (RESW/2)'(yr)};
    endfunction

    // Every cycle: predict outputs from model state plus current inputs, then advance
    always @(negedge clk) begin
        bit any;
        bit full;
        bit empty;
        int g;
        logic [NREQ-1:0] e_op_rdy;
        logic [NREQ-1:0] e_res_val;
        bit e_m_res_rdy;
        bit do_pop;
        bit do_push;
        if (rst) begin
            q_owner.delete();
            m_ptr = 0;
            m_err = 1'b0;
        end
        any   = (req_op_val != '0);
        full  = (q_owner.size() >= OSTD);
        empty = (q_owner.size() == 0);
        g = 0;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req_op_val[i]) begin
                g = i;
                break;
            end
        end
        e_op_rdy    = (any && !full && m_op_rdy) ? NREQ'(1 << g) : '0;
        e_m_res_rdy = !empty && req_res_rdy[empty ? 0 : q_owner[0]];
        e_res_val   = (!empty && m_res_val) ? NREQ'(1 << q_owner[0]) : '0;
        chk("m_op_val", 128'(m_op_val), 128'(any && !full));
        chk("req_op_rdy", 128'(req_op_rdy), 128'(e_op_rdy));
        if (any) chk("m_op_data", 128'(m_op_data), 128'(req_op_data[g*OPW +: OPW]));
        chk("m_res_rdy", 128'(m_res_rdy), 128'(e_m_res_rdy));
        chk("req_res_val", 128'(req_res_val), 128'(e_res_val));
        chk("req_res_data", 128'(req_res_data), 128'(m_res_data));
        chk("err", 128'(err), 128'(m_err));
        if (!rst) begin
            do_pop  = m_res_val && e_m_res_rdy;
            do_push = any && !full && m_op_rdy;
            if (sw_rst) begin
                q_owner.delete();
                m_ptr = 0;
                m_err = 1'b0;
            end else begin
                if (m_res_val && empty) m_err = 1'b1;
                if (do_pop) void'(q_owner.pop_front());
                if (do_push) begin
                    q_owner.push_back(g);
                    m_ptr = (g + 1) % NREQ;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sw_rst      = 1'b0;
        req_op_val  = '0;
        req_op_data = '0;
        req_res_rdy = '0;
        m_op_rdy    = 1'b0;
        m_res_val   = 1'b0;
        m_res_data  = '0;
    endtask

    task automatic swr();
        idle();
        sw_rst = 1'b1;
        cyc();
        sw_rst = 1'b0;
    endtask

    initial begin
        int exp_order[6] = '{0, 1, 2, 3, 0, 1};
        logic [OPW-1:0] slice0;

        idle();
        rst = 1'b1;
        cyc();
        cyc();
        #3;
        chk("rst_m_op_val", 128'(m_op_val), 128'(0));
        chk("rst_req_op_rdy", 128'(req_op_rdy), 128'(0));
        chk("rst_req_res_val", 128'(req_res_val), 128'(0));
        chk("rst_m_res_rdy", 128'(m_res_rdy), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        cyc();
        rst = 1'b0;
        cyc();

        // Single transaction: (3+4j)*(1+2j) = -5+10j
        req_op_val  = 4'b0001;
        req_op_data = {96'h0, pack_ops(3, 4, 1, 2)};
        m_op_rdy    = 1'b1;
        #3;
        chk("t1_m_op_data", 128'(m_op_data), 128'(32'h03040102));
        chk("t1_op_rdy", 128'(req_op_rdy), 128'(4'b0001));
        cyc();
        idle();
        m_res_val   = 1'b1;
        m_res_data  = cmul(3, 4, 1, 2);
        req_res_rdy = 4'b0001;
        #3;
        chk("t1_res_val", 128'(req_res_val), 128'(4'b0001));
        chk("t1_res_data", 128'(req_res_data), 128'({18'h3FFFB, 18'h0000A}));
        chk("t1_m_res_rdy", 128'(m_res_rdy), 128'(1));
        cyc();

        // All requesters valid: rotating grants, results routed to owners
        swr();
        req_op_val  = 4'b1111;
        req_op_data = {$urandom, $urandom, $urandom, $urandom};
        m_op_rdy    = 1'b1;
        req_res_rdy = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            m_res_val  = (k > 0);
            m_res_data = RESW'({$urandom, $urandom});
            #3;
            chk("rr_grant", 128'(req_op_rdy), 128'(1 << exp_order[k]));
            if (k > 0) chk("rr_route", 128'(req_res_val), 128'(1 << exp_order[k-1]));
            cyc();
        end

        // Fill four outstanding with the return path stalled
        swr();
        req_op_val  = 4'b0001;
        req_op_data = {$urandom, $urandom, $urandom, $urandom};
        m_op_rdy    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #3;
            chk("fill_rdy", 128'(req_op_rdy), 128'(4'b0001));
            cyc();
            m_res_val = 1'b1;
        end
        #3;
        chk("full_rdy", 128'(req_op_rdy), 128'(0));
        chk("full_m_op_val", 128'(m_op_val), 128'(0));
        cyc();
        req_res_rdy = 4'b0001;
        #3;
        chk("full_pop_rdy", 128'(req_op_rdy), 128'(0));
        chk("full_m_res_rdy", 128'(m_res_rdy), 128'(1));
        cyc();
        req_res_rdy = 4'b0000;
        #3;
        chk("after_pop_rdy", 128'(req_op_rdy), 128'(4'b0001));
        cyc();

        // Pointer at 3 with requesters 1 and 2 pending
        swr();
        req_op_val = 4'b0100;
        m_op_rdy   = 1'b1;
        #3;
        chk("ptr_setup", 128'(req_op_rdy), 128'(4'b0100));
        cyc();
        req_op_val = 4'b0110;
        #3;
        chk("wrap_first", 128'(req_op_rdy), 128'(4'b0010));
        cyc();
        #3;
        chk("wrap_second", 128'(req_op_rdy), 128'(4'b0100));
        cyc();

        // Stray result with nothing outstanding
        swr();
        m_res_val = 1'b1;
        #3;
        chk("stray_m_res_rdy", 128'(m_res_rdy), 128'(0));
        cyc();
        m_res_val = 1'b0;
        #3;
        chk("stray_err", 128'(err), 128'(1));
        cyc();
        sw_rst = 1'b1;
        #3;
        chk("err_held", 128'(err), 128'(1));
        cyc();
        sw_rst = 1'b0;
        #3;
        chk("err_cleared", 128'(err), 128'(0));

        // Hard reset with two outstanding
        swr();
        req_op_val  = 4'b0011;
        req_op_data = {$urandom, $urandom, $urandom, $urandom};
        m_op_rdy    = 1'b1;
        cyc();
        cyc();
        idle();
        rst         = 1'b1;
        m_res_val   = 1'b1;
        req_res_rdy = 4'b1111;
        #3;
        chk("hrst_res_val", 128'(req_res_val), 128'(0));
        chk("hrst_m_res_rdy", 128'(m_res_rdy), 128'(0));
        chk("hrst_err", 128'(err), 128'(0));
        cyc();
        rst         = 1'b0;
        req_op_val  = 4'b1111;
        req_op_data = {$urandom, $urandom, $urandom, $urandom};
        slice0      = req_op_data[OPW-1:0];
        #3;
        chk("hrst_ptr0", 128'(m_op_data), 128'(slice0));
        cyc();
        idle();
        #3;
        chk("late_result_err", 128'(err), 128'(1));
        cyc();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(299) == 0);
            sw_rst      = ($urandom_range(63) == 0);
            req_op_val  = NREQ'($urandom) & NREQ'($urandom | $urandom);
            req_op_data = {$urandom, $urandom, $urandom, $urandom};
            m_op_rdy    = ($urandom_range(3) != 0);
            if (q_owner.size() > 0) m_res_val = ($urandom_range(2) != 0);
            else                    m_res_val = ($urandom_range(199) == 0);
            m_res_data  = RESW'({$urandom, $urandom});
            req_res_rdy = NREQ'($urandom) | NREQ'($urandom);
            cyc();
        end
        rst = 1'b0;
        idle();
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_comp_mult_arb
`default_nettype wire
